logo_motion_ctrl: RTL and testbench
===================================

# logo_motion_ctrl

Frame-rate motion controller for the pixel-stream overlay datapath. It watches the VGA stream for end of the visible frame and, during blanking, computes the next upper-left position of the bouncing object. Wall collisions clamp the position and reverse direction. Speed requests from user inputs are applied at the frame boundary. Its `x_obj`/`y_obj` outputs drive the position inputs of the logo/ball overlay stage, and its bounce strobes feed the sound block.

## Interface
Parameters:
- `WIDTH_OBJ`, 80, object width in pixels
- `HEIGHT_OBJ`, 96, object height in pixels
- `VISIBLECOLS`, 640, visible columns
- `VISIBLEROWS`, 480, visible rows
- `BORDER`, 0, wall inset in pixels on all sides
- `SPEED_INIT`, 1, speed after reset (pixels/frame)
- `SPEED_MAX`, 15, speed saturation ceiling (≤ 31)

Ports:
- `px_clk`  in  1  pixel clock; all logic is clocked on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `RGBStr_i`  in  26  VGA stream; only XC[22:13] and YC[12:3] are used
- `inc_vel`  in  1  one-cycle request: speed +1
- `dec_vel`  in  1  one-cycle request: speed −1
- `pause`  in  1  level; freezes motion while high
- `x_obj`  out  10  object left X coordinate
- `y_obj`  out  10  object top Y coordinate
- `speed`  out  5  current speed
- `bounce_x`  out  1  one-cycle strobe on vertical-wall bounce
- `bounce_y`  out  1  one-cycle strobe on horizontal-wall bounce
- `frame_tick`  out  1  one-cycle strobe when a new position is committed

## Operation
- Derived limits:
  - X_MIN = BORDER, X_MAX = VISIBLECOLS − WIDTH_OBJ − BORDER (560 by default).
  - Y_MIN = BORDER, Y_MAX = VISIBLEROWS − HEIGHT_OBJ − BORDER (384 by default).
- Reset values:
  - `x_obj` = (VISIBLECOLS−WIDTH_OBJ)/2 = 280; `y_obj` = (VISIBLEROWS−HEIGHT_OBJ)/2 = 192.
  - dx = 0 (moving right), dy = 0 (moving down).
  - `speed` = SPEED_INIT.
  - All strobes 0; pending-request flags 0; state IDLE.
- endframe condition: XC == VISIBLECOLS−1 and YC == VISIBLEROWS−1. Only the rising edge, registered, triggers the FSM, so one trigger occurs per frame regardless of how long the condition lasts.
- Request latching:
  - `inc_vel`/`dec_vel` pulses set the sticky flags inc_p/dec_p in any state.
  - The flags are cleared only in COMMIT.
- FSM states:
  - **IDLE**: on trigger, go to CALC_X if `pause`=0; if `pause`=1, stay in IDLE and do nothing (flags retained).
  - **CALC_X**: compute nx in 11-bit unsigned arithmetic.
    - dx=0: nx = x+speed. If nx ≥ X_MAX, set nx = X_MAX, dx=1 and flag bx.
    - dx=1: if x ≤ X_MIN+speed, set nx = X_MIN, dx=0 and flag bx; else nx = x−speed.
    - Then go to CALC_Y.
  - **CALC_Y**: same rule on y with Y_MIN/Y_MAX and dy, producing ny and flag by. Then go to COMMIT.
  - **COMMIT**:
    - Load `x_obj`←nx and `y_obj`←ny in the same cycle.
    - Pulse `frame_tick`; pulse `bounce_x`/`bounce_y` if bx/by is set.
    - Update speed:
      - inc_p only: min(speed+1, SPEED_MAX).
      - dec_p only: max(speed−1, 0).
      - both or neither: unchanged.
    - Clear inc_p, dec_p, bx, by. Go to IDLE.
- Special cases:
  - At speed 0, no movement and no bounce (the clamp cannot trigger unless the position is already at a limit; at a limit it reflects with zero displacement and strobes).
  - Simultaneous X and Y bounce: both strobes pulse in the same cycle.
  - A request arriving in the COMMIT cycle is applied in that COMMIT.
- Position never leaves [X_MIN, X_MAX] × [Y_MIN, Y_MAX].

## Timing
- Trigger is registered one cycle after the endframe pixel (cycle N).
- Cycle sequence: CALC_X at N+1, CALC_Y at N+2, COMMIT at N+3.
- New `x_obj`/`y_obj`/`speed` and all strobes are visible at N+4. The update completes well inside vertical blanking.
- Outputs are held constant between commits, so the overlay sees a stable position for a whole frame.
- Strobes are exactly one `px_clk` cycle wide.
- Asserting `reset_n` low in any state immediately forces all reset values. After release, the block waits in IDLE for the next endframe edge.

## Configuration
- `LOGO_MOTION_AUTOSPEED_EN`:
  - Defined: a 2-bit bounce counter increments on every COMMIT with bx or by set. Each time it wraps (every 4th bouncing frame), speed increases by 1, saturating at SPEED_MAX. This increase is added on top of any inc/dec result in that same COMMIT and is then re-saturated. The counter resets to 0.
  - Undefined: speed changes only via `inc_vel`/`dec_vel`; no counter exists.

## Test plan
- Reset: `reset_n`=0 → `x_obj`=280, `y_obj`=192, `speed`=1, all strobes 0. After release, no output change before the first endframe.
- Free run, speed 1: drive XC=639/YC=479 once → at N+4 `x_obj`=281, `y_obj`=193, `frame_tick` high for 1 cycle, no bounce strobe.
- Right-wall clamp: set speed 15 with x=550 moving right → commit gives `x_obj`=560, `bounce_x`=1 for one cycle; the next frame gives `x_obj`=545.
- Speed control:
  - 20 `inc_vel` pulses → `speed`=15.
  - `inc_vel` and `dec_vel` in the same frame → unchanged.
  - `dec_vel` at 0 → 0, and the position stays frozen over 3 frames.
- `pause`=1 across two endframes with one `inc_vel` → no `frame_tick`, position unchanged. After `pause`=0, the next commit moves the object and speed becomes 2.
- Corner and reset mid-operation:
  - Start at x=560, y=384 moving right/down → `bounce_x` and `bounce_y` pulse in the same cycle.
  - Pulling `reset_n` low during CALC_Y → outputs return to reset values at once.
  - With `LOGO_MOTION_AUTOSPEED_EN` defined: 4 bouncing frames → speed +1.

Source files
------------

// File: rtl/logo_motion_ctrl.sv
// logo_motion_ctrl
//   Frame-rate motion controller for the bouncing overlay object. It detects the
//   end of the visible frame on the VGA stream. During blanking it then steps the
//   object's upper-left corner by `speed` pixels per axis. When the object reaches
//   a wall, its position is clamped and its direction on that axis reverses.
//   Speed requests are collected during the frame and applied when the new
//   position is committed.
//
// Ports
//   px_clk      pixel clock (rising edge)
//   reset_n     asynchronous active-low reset
//   RGBStr_i    VGA stream; XC = [22:13], YC = [12:3], other bits ignored
//   inc_vel     one-cycle request: speed + 1 at the next commit
//   dec_vel     one-cycle request: speed - 1 at the next commit
//   pause       level; while high, frame boundaries are ignored
//   x_obj       object left X coordinate
//   y_obj       object top Y coordinate
//   speed       current speed in pixels per frame
//   bounce_x    one-cycle strobe: a vertical wall was hit in this commit
//   bounce_y    one-cycle strobe: a horizontal wall was hit in this commit
//   frame_tick  one-cycle strobe: a new position was committed
//
// Configuration
//   LOGO_MOTION_AUTOSPEED_EN  when defined, every 4th commit that contains a
//                             bounce raises the speed by one (saturating).

module logo_motion_ctrl #(
    parameter int WIDTH_OBJ   = 80,
    parameter int HEIGHT_OBJ  = 96,
    parameter int VISIBLECOLS = 640,
    parameter int VISIBLEROWS = 480,
    parameter int BORDER      = 0,
    parameter int SPEED_INIT  = 1,
    parameter int SPEED_MAX   = 15
) (
    input  logic        px_clk,
    input  logic        reset_n,
    input  logic [25:0] RGBStr_i,
    input  logic        inc_vel,
    input  logic        dec_vel,
    input  logic        pause,
    output logic [9:0]  x_obj,
    output logic [9:0]  y_obj,
    output logic [4:0]  speed,
    output logic        bounce_x,
    output logic        bounce_y,
    output logic        frame_tick
);

    localparam logic [10:0] X_MIN    = 11'(BORDER);
    localparam logic [10:0] X_MAX    = 11'(VISIBLECOLS - WIDTH_OBJ - BORDER);
    localparam logic [10:0] Y_MIN    = 11'(BORDER);
    localparam logic [10:0] Y_MAX    = 11'(VISIBLEROWS - HEIGHT_OBJ - BORDER);
    localparam logic [9:0]  X_RST    = 10'((VISIBLECOLS - WIDTH_OBJ) / 2);
    localparam logic [9:0]  Y_RST    = 10'((VISIBLEROWS - HEIGHT_OBJ) / 2);
    localparam logic [9:0]  XC_END   = 10'(VISIBLECOLS - 1);
    localparam logic [9:0]  YC_END   = 10'(VISIBLEROWS - 1);
    localparam logic [4:0]  SPD_INIT = 5'(SPEED_INIT);
    localparam logic [4:0]  SPD_MAX  = 5'(SPEED_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;   // 0: towards max, 1: towards min
        logic       hit;
    } step_t;

    // One axis of motion in 11-bit unsigned arithmetic. Moving towards max, the
    // object clamps as soon as it touches the limit. Moving towards min, the
    // check is written as pos <= lo + spd so the subtraction never wraps.
    function automatic step_t axis_step(
        input logic [9:0]  pos,
        input logic        dir,
        input logic [4:0]  spd,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        logic [10:0] p11;
        logic [10:0] s11;
        logic [10:0] sum;
        step_t       r;
        p11   = {1'b0, pos};
        s11   = {6'd0, spd};
        sum   = p11 + s11;
        r.pos = pos;
        r.dir = dir;
        r.hit = 1'b0;
        if (!dir) begin
            if (sum >= hi) begin
                r.pos = hi[9:0];
                r.dir = 1'b1;
                r.hit = 1'b1;
            end else begin
                r.pos = sum[9:0];
            end
        end else begin
            if (p11 <= lo + s11) begin
                r.pos = lo[9:0];
                r.dir = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.pos = pos - 10'(spd);
            end
        end
        return r;
    endfunction

    // Speed update: one step up or down (down floors at 0). An optional bump is
    // added on top, and the result is saturated at SPD_MAX.
    function automatic logic [4:0] sat_speed(
        input logic [4:0] spd,
        input logic       inc,
        input logic       dec,
        input logic       bump
    );
        logic [5:0] s;
        s = {1'b0, spd};
        if (inc && !dec) begin
            s = s + 6'd1;
        end else if (dec && !inc && (s != 6'd0)) begin
            s = s - 6'd1;
        end
        if (bump) begin
            s = s + 6'd1;
        end
        if (s > {1'b0, SPD_MAX}) begin
            s = {1'b0, SPD_MAX};
        end
        return s[4:0];
    endfunction

    state_t     state;
    state_t     state_nxt;
    logic [9:0] xc;
    logic [9:0] yc;
    logic       unused_stream;
    logic       endframe;
    logic       endframe_p0;
    logic       trig_p0;
    logic       dx;
    logic       dy;
    logic       bx;
    logic       by;
    logic       inc_p;
    logic       dec_p;
    logic [9:0] nx;
    logic [9:0] ny;
    logic       bump;
    step_t      step_res;

    assign xc            = RGBStr_i[22:13];
    assign yc            = RGBStr_i[12:3];
    assign unused_stream = ^{RGBStr_i[25:23], RGBStr_i[2:0]};
    assign endframe      = (xc == XC_END) && (yc == YC_END);

    // ---- stage p0: register endframe and its rising edge (one trigger per frame)
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            endframe_p0 <= 1'b0;
            trig_p0     <= 1'b0;
        end else begin
            endframe_p0 <= endframe;
            trig_p0     <= endframe & ~endframe_p0;
        end
    end

    // ---- FSM
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig_p0 && !pause) state_nxt = CALC_X;
            CALC_X:  state_nxt = CALC_Y;
            CALC_Y:  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A single step unit serves both axes; X and Y use it in separate cycles.
    always_comb begin
        if (state == CALC_Y) begin
            step_res = axis_step(y_obj, dy, speed, Y_MIN, Y_MAX);
        end else begin
            step_res = axis_step(x_obj, dx, speed, X_MIN, X_MAX);
        end
    end

`ifdef LOGO_MOTION_AUTOSPEED_EN
    logic [1:0] bnc_cnt;

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            bnc_cnt <= 2'd0;
        end else if ((state == COMMIT) && (bx || by)) begin
            bnc_cnt <= bnc_cnt + 2'd1;
        end
    end

    // The counter wraps on this commit, so this is the 4th bouncing frame.
    assign bump = (bx || by) && (bnc_cnt == 2'd3);
`else
    assign bump = 1'b0;
`endif

    // ---- datapath: step results, commit, speed and strobes
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_obj      <= X_RST;
            y_obj      <= Y_RST;
            nx         <= X_RST;
            ny         <= Y_RST;
            dx         <= 1'b0;
            dy         <= 1'b0;
            bx         <= 1'b0;
            by         <= 1'b0;
            inc_p      <= 1'b0;
            dec_p      <= 1'b0;
            speed      <= SPD_INIT;
            frame_tick <= 1'b0;
            bounce_x   <= 1'b0;
            bounce_y   <= 1'b0;
        end else begin
            inc_p      <= inc_p | inc_vel;
            dec_p      <= dec_p | dec_vel;
            frame_tick <= 1'b0;
            bounce_x   <= 1'b0;
            bounce_y   <= 1'b0;
            case (state)
                CALC_X: begin
                    nx <= step_res.pos;
                    dx <= step_res.dir;
                    bx <= step_res.hit;
                end
                CALC_Y: begin
                    ny <= step_res.pos;
                    dy <= step_res.dir;
                    by <= step_res.hit;
                end
                COMMIT: begin
                    x_obj      <= nx;
                    y_obj      <= ny;
                    frame_tick <= 1'b1;
                    bounce_x   <= bx;
                    bounce_y   <= by;
                    // A request arriving in this very cycle is honoured here.
                    speed      <= sat_speed(speed, inc_p | inc_vel, dec_p | dec_vel, bump);
                    inc_p      <= 1'b0;
                    dec_p      <= 1'b0;
                    bx         <= 1'b0;
                    by         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logo_motion_ctrl.sv
`timescale 1ns/1ps
module tb_logo_motion_ctrl;

    localparam int SPMAX = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [25:0] rgb;
    logic        inc_vel, dec_vel, pause;
    logic [9:0]  x_obj, y_obj;
    logic [4:0]  speed;
    logic        bounce_x, bounce_y, frame_tick;
    // full-screen object: both axes sit permanently at their limits
    logic [9:0]  cx, cy;
    logic [4:0]  cspd;
    logic        cbx, cby, ctick;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logo_motion_ctrl dut (
        .px_clk(clk), .reset_n(reset_n), .RGBStr_i(rgb),
        .inc_vel(inc_vel), .dec_vel(dec_vel), .pause(pause),
        .x_obj(x_obj), .y_obj(y_obj), .speed(speed),
        .bounce_x(bounce_x), .bounce_y(bounce_y), .frame_tick(frame_tick)
    );

    logo_motion_ctrl #(.WIDTH_OBJ(640), .HEIGHT_OBJ(480)) dut_full (
        .px_clk(clk), .reset_n(reset_n), .RGBStr_i(rgb),
        .inc_vel(inc_vel), .dec_vel(dec_vel), .pause(pause),
        .x_obj(cx), .y_obj(cy), .speed(cspd),
        .bounce_x(cbx), .bounce_y(cby), .frame_tick(ctick)
    );

    // ---------------- reference model (per-frame, signed velocity view)
    typedef struct {
        int x; int y; int dx; int dy; int spd; int cnt;
        bit inc; bit dec; bit bx; bit by;
    } mstate_t;

    mstate_t m, mc;

    function automatic mstate_t model_init(input int x, input int y);
        mstate_t r;
        r.x = x; r.y = y; r.dx = 0; r.dy = 0; r.spd = 1; r.cnt = 0;
        r.inc = 0; r.dec = 0; r.bx = 0; r.by = 0;
        return r;
    endfunction

    function automatic mstate_t model_frame(input mstate_t st, input int xhi, input int yhi);
        mstate_t r;
        int vx, vy, tx, ty, ns;
        r  = st;
        vx = (st.dx != 0) ? -st.spd : st.spd;
        vy = (st.dy != 0) ? -st.spd : st.spd;
        tx = st.x + vx;
        ty = st.y + vy;
        r.bx = (st.dx == 0) ? (tx >= xhi) : (tx <= 0);
        r.by = (st.dy == 0) ? (ty >= yhi) : (ty <= 0);
        if (r.bx) begin r.x = (st.dx == 0) ? xhi : 0; r.dx = 1 - st.dx; end else r.x = tx;
        if (r.by) begin r.y = (st.dy == 0) ? yhi : 0; r.dy = 1 - st.dy; end else r.y = ty;
        ns = st.spd;
        if (st.inc && !st.dec) ns = ns + 1;
        else if (st.dec && !st.inc) ns = ns - 1;
        if (ns < 0) ns = 0;
        if (ns > SPMAX) ns = SPMAX;
`ifdef LOGO_MOTION_AUTOSPEED_EN
        if (r.bx || r.by) begin
            r.cnt = (st.cnt + 1) % 4;
            if (r.cnt == 0) ns = ns + 1;
        end
        if (ns > SPMAX) ns = SPMAX;
`endif
        r.spd = ns;
        r.inc = 0;
        r.dec = 0;
        return r;
    endfunction

    task automatic model_step(input bit inc, input bit dec, input bit pz);
        m.inc  = m.inc | inc;   m.dec  = m.dec | dec;
        mc.inc = mc.inc | inc;  mc.dec = mc.dec | dec;
        if (!pz) begin
            m  = model_frame(m, 560, 384);
            mc = model_frame(mc, 0, 0);
        end
    endtask

    // ---------------- stimulus helpers
    typedef struct {
        int ntick; int nctick; int lat;
        logic bx; logic by; logic cbx; logic cby;
        bit clean;
    } obs_t;

    task automatic drive_pixel(input bit ef);
        logic [9:0] xc, yc;
        if (ef) begin
            xc = 10'd639; yc = 10'd479;
        end else begin
            xc = 10'($urandom_range(0, 799));
            yc = 10'($urandom_range(0, 524));
            if (xc == 10'd639 && yc == 10'd479) xc = 10'd0;
        end
        rgb = {3'($urandom_range(0, 7)), xc, yc, 3'($urandom_range(0, 7))};
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0; pause = 1'b0;
        drive_pixel(1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m  = model_init(280, 192);
        mc = model_init(0, 0);
    endtask

    // One frame: random-length active region with optional request pulses, then
    // the endframe pixel held for ef_len cycles, then a blanking window watched
    // for strobes. lat is the edge index (0 = edge that registers the trigger).
    task automatic do_frame(input bit inc, input bit dec, input bit pz, input int ef_len, output obs_t o);
        int gap, inc_at, dec_at;
        gap    = $urandom_range(3, 10);
        inc_at = $urandom_range(0, gap - 1);
        dec_at = $urandom_range(0, gap - 1);
        o.ntick = 0; o.nctick = 0; o.lat = -1; o.clean = 1'b1;
        o.bx = 1'b0; o.by = 1'b0; o.cbx = 1'b0; o.cby = 1'b0;
        pause = pz;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            drive_pixel(1'b0);
            inc_vel = inc && (i == inc_at);
            dec_vel = dec && (i == dec_at);
        end
        for (int i = 0; i < ef_len; i++) begin
            @(negedge clk);
            drive_pixel(1'b1);
            inc_vel = 1'b0; dec_vel = 1'b0;
        end
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drive_pixel(1'b0);
            if (frame_tick === 1'b1) begin
                if (o.ntick == 0) begin
                    o.lat = ef_len - 1 + k;
                    o.bx = bounce_x; o.by = bounce_y; o.cbx = cbx; o.cby = cby;
                end
                o.ntick++;
            end
            if (ctick === 1'b1) o.nctick++;
            if (ctick !== frame_tick) o.clean = 1'b0;
            if ((bounce_x || bounce_y || cbx || cby) && !frame_tick) o.clean = 1'b0;
        end
    endtask

    // ---------------- tests
    task automatic test_reset();
        int chg;
        reset_n = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0; pause = 1'b0;
        drive_pixel(1'b0);
        repeat (2) @(negedge clk);
        n_cmp++; if (x_obj !== 10'd280 || y_obj !== 10'd192) begin n_fail++;
            $display("FAIL reset_pos: got x=%0d y=%0d, want 280/192", x_obj, y_obj); end
        n_cmp++; if (speed !== 5'd1) begin n_fail++;
            $display("FAIL reset_speed: got %0d, want 1", speed); end
        n_cmp++; if ({frame_tick, bounce_x, bounce_y} !== 3'b000) begin n_fail++;
            $display("FAIL reset_strobes: got %b, want 000", {frame_tick, bounce_x, bounce_y}); end
        n_cmp++; if (cx !== 10'd0 || cy !== 10'd0) begin n_fail++;
            $display("FAIL reset_full_pos: got %0d/%0d, want 0/0", cx, cy); end
        reset_n = 1'b1;
        m  = model_init(280, 192);
        mc = model_init(0, 0);
        chg = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive_pixel(1'b0);
            if (x_obj !== 10'd280 || y_obj !== 10'd192 || speed !== 5'd1 || frame_tick !== 1'b0) chg++;
        end
        n_cmp++; if (chg != 0) begin n_fail++;
            $display("FAIL reset_hold: %0d cycles changed before endframe, want 0", chg); end
    endtask

    task automatic test_free_run();
        obs_t o;
        apply_reset();
        do_frame(1'b0, 1'b0, 1'b0, 1, o);
        model_step(1'b0, 1'b0, 1'b0);
        n_cmp++; if (o.ntick != 1 || !o.clean) begin n_fail++;
            $display("FAIL free_tick: ticks=%0d clean=%0d, want 1/1", o.ntick, o.clean); end
        n_cmp++; if (o.lat != 4) begin n_fail++;
            $display("FAIL free_latency: got edge %0d, want 4", o.lat); end
        n_cmp++; if (x_obj !== 10'd281 || y_obj !== 10'd193) begin n_fail++;
            $display("FAIL free_pos: got %0d/%0d, want 281/193", x_obj, y_obj); end
        n_cmp++; if (o.bx !== 1'b0 || o.by !== 1'b0) begin n_fail++;
            $display("FAIL free_bounce: got %b%b, want 00", o.bx, o.by); end
    endtask

    task automatic test_wall_clamp();
        obs_t o;
        bit inc;
        apply_reset();
        for (int f = 1; f <= 27; f++) begin
            inc = (f <= 20);
            do_frame(inc, 1'b0, 1'b0, $urandom_range(1, 3), o);
            model_step(inc, 1'b0, 1'b0);
            n_cmp++; if (x_obj !== 10'(m.x) || y_obj !== 10'(m.y) || speed !== 5'(m.spd)) begin n_fail++;
                $display("FAIL clamp_frame%0d: got x=%0d y=%0d s=%0d, want %0d/%0d/%0d",
                         f, x_obj, y_obj, speed, m.x, m.y, m.spd); end
            if (f == 20) begin
                n_cmp++; if (speed !== 5'd15) begin n_fail++;
                    $display("FAIL inc_saturate: got %0d, want 15", speed); end
            end
            if (f == 25) begin
                n_cmp++; if (x_obj !== 10'd550) begin n_fail++;
                    $display("FAIL clamp_setup: got x=%0d, want 550", x_obj); end
            end
            if (f == 26) begin
                n_cmp++; if (x_obj !== 10'd560 || o.bx !== 1'b1 || !o.clean || o.ntick != 1) begin n_fail++;
                    $display("FAIL clamp_right: got x=%0d bx=%b clean=%0d, want 560/1/1", x_obj, o.bx, o.clean); end
            end
            if (f == 27) begin
                n_cmp++; if (x_obj !== 10'd545 || o.bx !== 1'b0) begin n_fail++;
                    $display("FAIL clamp_reflect: got x=%0d bx=%b, want 545/0", x_obj, o.bx); end
            end
        end
    endtask

    task automatic test_speed_control();
        obs_t o;
        logic [9:0] fx, fy;
        apply_reset();
        do_frame(1'b1, 1'b1, 1'b0, 2, o);
        model_step(1'b1, 1'b1, 1'b0);
        n_cmp++; if (speed !== 5'd1 || o.ntick != 1) begin n_fail++;
            $display("FAIL inc_dec_same: got speed=%0d ticks=%0d, want 1/1", speed, o.ntick); end
        do_frame(1'b0, 1'b1, 1'b0, 1, o);
        model_step(1'b0, 1'b1, 1'b0);
        n_cmp++; if (speed !== 5'd0) begin n_fail++;
            $display("FAIL dec_to_zero: got %0d, want 0", speed); end
        fx = x_obj; fy = y_obj;
        for (int f = 0; f < 3; f++) begin
            do_frame(1'b0, 1'b1, 1'b0, 3, o);
            model_step(1'b0, 1'b1, 1'b0);
            n_cmp++; if (speed !== 5'd0 || x_obj !== fx || y_obj !== fy || o.bx !== 1'b0 || o.by !== 1'b0) begin n_fail++;
                $display("FAIL zero_frozen%0d: got s=%0d x=%0d y=%0d b=%b%b, want 0/%0d/%0d/00",
                         f, speed, x_obj, y_obj, o.bx, o.by, fx, fy); end
        end
    endtask

    task automatic test_pause();
        obs_t o;
        apply_reset();
        do_frame(1'b1, 1'b0, 1'b1, 1, o);
        model_step(1'b1, 1'b0, 1'b1);
        n_cmp++; if (o.ntick != 0 || x_obj !== 10'd280 || y_obj !== 10'd192 || speed !== 5'd1) begin n_fail++;
            $display("FAIL pause_1: got ticks=%0d x=%0d y=%0d s=%0d, want 0/280/192/1", o.ntick, x_obj, y_obj, speed); end
        do_frame(1'b0, 1'b0, 1'b1, 2, o);
        model_step(1'b0, 1'b0, 1'b1);
        n_cmp++; if (o.ntick != 0 || x_obj !== 10'd280 || y_obj !== 10'd192) begin n_fail++;
            $display("FAIL pause_2: got ticks=%0d x=%0d y=%0d, want 0/280/192", o.ntick, x_obj, y_obj); end
        do_frame(1'b0, 1'b0, 1'b0, 1, o);
        model_step(1'b0, 1'b0, 1'b0);
        n_cmp++; if (o.ntick != 1 || x_obj !== 10'd281 || y_obj !== 10'd193 || speed !== 5'd2) begin n_fail++;
            $display("FAIL pause_resume: got ticks=%0d x=%0d y=%0d s=%0d, want 1/281/193/2", o.ntick, x_obj, y_obj, speed); end
    endtask

    task automatic test_corner();
        obs_t o;
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            do_frame(1'b0, (f == 1), 1'b0, 1, o);
            model_step(1'b0, (f == 1), 1'b0);
            n_cmp++; if (o.cbx !== 1'b1 || o.cby !== 1'b1 || o.nctick != 1 || !o.clean) begin n_fail++;
                $display("FAIL corner_both%0d: got bx=%b by=%b ticks=%0d clean=%0d, want 1/1/1/1",
                         f, o.cbx, o.cby, o.nctick, o.clean); end
            n_cmp++; if (cx !== 10'd0 || cy !== 10'd0 || cspd !== 5'(mc.spd)) begin n_fail++;
                $display("FAIL corner_state%0d: got %0d/%0d s=%0d, want 0/0 s=%0d", f, cx, cy, cspd, mc.spd); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int stray;
        apply_reset();
        do_frame(1'b1, 1'b0, 1'b0, 1, o);
        do_frame(1'b1, 1'b0, 1'b0, 1, o);
        @(negedge clk); drive_pixel(1'b1);
        @(negedge clk); drive_pixel(1'b0);   // trigger registered
        @(negedge clk);                      // CALC_X
        @(negedge clk);                      // CALC_Y
        n_cmp++; if (x_obj !== 10'd283 || speed !== 5'd3) begin n_fail++;
            $display("FAIL mid_before: got x=%0d s=%0d, want 283/3", x_obj, speed); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (x_obj !== 10'd280 || y_obj !== 10'd192 || speed !== 5'd1 ||
                     {frame_tick, bounce_x, bounce_y} !== 3'b000) begin n_fail++;
            $display("FAIL mid_reset: got x=%0d y=%0d s=%0d st=%b, want 280/192/1/000",
                     x_obj, y_obj, speed, {frame_tick, bounce_x, bounce_y}); end
        @(negedge clk);
        reset_n = 1'b1;
        m  = model_init(280, 192);
        mc = model_init(0, 0);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_pixel(1'b0);
            if (frame_tick !== 1'b0 || x_obj !== 10'd280) stray++;
        end
        n_cmp++; if (stray != 0) begin n_fail++;
            $display("FAIL mid_after: %0d cycles with commit activity, want 0", stray); end
    endtask

    task automatic test_random();
        obs_t o;
        bit inc, dec, pz;
        apply_reset();
        for (int f = 0; f < 60; f++) begin
            inc = ($urandom_range(0, 2) != 0);
            dec = ($urandom_range(0, 3) == 0);
            pz  = ($urandom_range(0, 4) == 0);
            do_frame(inc, dec, pz, $urandom_range(1, 3), o);
            model_step(inc, dec, pz);
            n_cmp++; if (o.ntick != (pz ? 0 : 1) || !o.clean || (!pz && o.lat != 4)) begin n_fail++;
                $display("FAIL rand_tick%0d: got ticks=%0d lat=%0d clean=%0d, want %0d/4/1",
                         f, o.ntick, o.lat, o.clean, pz ? 0 : 1); end
            n_cmp++; if (x_obj !== 10'(m.x) || y_obj !== 10'(m.y) || speed !== 5'(m.spd)) begin n_fail++;
                $display("FAIL rand_state%0d: got %0d/%0d s=%0d, want %0d/%0d s=%0d",
                         f, x_obj, y_obj, speed, m.x, m.y, m.spd); end
            n_cmp++; if (o.bx !== (pz ? 1'b0 : m.bx) || o.by !== (pz ? 1'b0 : m.by)) begin n_fail++;
                $display("FAIL rand_bounce%0d: got %b%b, want %b%b",
                         f, o.bx, o.by, pz ? 1'b0 : m.bx, pz ? 1'b0 : m.by); end
            n_cmp++; if (cspd !== 5'(mc.spd)) begin n_fail++;
                $display("FAIL rand_full_speed%0d: got %0d, want %0d", f, cspd, mc.spd); end
        end
    endtask

`ifdef LOGO_MOTION_AUTOSPEED_EN
    task automatic test_autospeed();
        obs_t o;
        apply_reset();
        for (int f = 1; f <= 4; f++) begin
            do_frame(1'b0, 1'b0, 1'b0, 1, o);
            model_step(1'b0, 1'b0, 1'b0);
            n_cmp++; if (cspd !== ((f < 4) ? 5'd1 : 5'd2)) begin n_fail++;
                $display("FAIL autospeed%0d: got %0d, want %0d", f, cspd, (f < 4) ? 1 : 2); end
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0; pause = 1'b0; rgb = '0;
        test_reset();
        test_free_run();
        test_wall_clamp();
        test_speed_control();
        test_pause();
        test_corner();
        test_reset_mid();
        test_random();
`ifdef LOGO_MOTION_AUTOSPEED_EN
        test_autospeed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
